nmr_bstrm_seq_loader: RTL and testbench

//  Upstream loader for the NMR bitstream pulse engine. Packs 32-bit host beats into 128-bit sequence

---
 rtl/nmr_bstrm_pkg.sv | 50 +++++
 rtl/nmr_bstrm_word_packer.sv | 43 ++++
 rtl/nmr_bstrm_seq_loader.sv | 153 +++++++++++++++
 tb/tb_nmr_bstrm_seq_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_bstrm_pkg.sv
// Shared definitions for the NMR bitstream sequence loader: sequence word
// layout, host beat geometry and the loader FSM state type.
package nmr_bstrm_pkg;

    localparam int SEQ_HOST_W     = 32;
    localparam int SEQ_DAT_W      = 128;
    localparam int SEQ_BE_W       = SEQ_DAT_W / 8;
    localparam int SEQ_AW         = 8;
    localparam int BEATS_PER_WORD = SEQ_DAT_W / SEQ_HOST_W;
    localparam int LANE_W         = $clog2(BEATS_PER_WORD);

    // Field LSB offsets inside one 128-bit sequence word
    localparam int CMD_LSB  = 0;
    localparam int LOOP_LSB = 16;
    localparam int IDLY_LSB = 32;
    localparam int PLS_LSB  = 64;
    localparam int EDLY_LSB = 96;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        DRAIN  = 3'd3,
        LOADED = 3'd4,
        FIRE   = 3'd5,
        RUN    = 3'd6
    } seq_ld_state_t;

    // Drops one host beat into its lane; lane 0 carries CMD in its low half
    // and LOOP in its high half, the other lanes carry one 32-bit field each.
    function automatic logic [SEQ_DAT_W-1:0] place_beat(
        input logic [SEQ_DAT_W-1:0]  word,
        input logic [LANE_W-1:0]     lane,
        input logic [SEQ_HOST_W-1:0] beat
    );
        logic [SEQ_DAT_W-1:0] w;
        w = word;
        case (lane)
            2'd0: begin
                w[CMD_LSB  +: 16] = beat[15:0];
                w[LOOP_LSB +: 16] = beat[31:16];
            end
            2'd1:    w[IDLY_LSB +: 32] = beat;
            2'd2:    w[PLS_LSB  +: 32] = beat;
            default: w[EDLY_LSB +: 32] = beat;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/nmr_bstrm_word_packer.sv
// Collects host beats into one sequence word. Lanes that never receive a
// beat stay zero because the pack register is cleared after every write.
module nmr_bstrm_word_packer
    import nmr_bstrm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  beat_valid,
    input  logic [SEQ_HOST_W-1:0] beat_dat,
    input  logic                  beat_last,
    output logic                  word_done,
    output logic [SEQ_DAT_W-1:0]  word,
    output logic                  word_last
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEATS_PER_WORD - 1);

    logic [LANE_W-1:0] lane;

    // A word is complete when its top lane fills or the sequence ends early
    always_comb begin
        word_done = beat_valid && ((lane == LAST_LANE) || beat_last);
    end

    // Lane counter and pack register; clear wins over an incoming beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane      <= '0;
            word      <= '0;
            word_last <= 1'b0;
        end else if (clear) begin
            lane      <= '0;
            word      <= '0;
            word_last <= 1'b0;
        end else if (beat_valid) begin
            word      <= place_beat(word, lane, beat_dat);
            lane      <= lane + 1'b1;
            word_last <= beat_last;
        end
    end

endmodule

// File: rtl/nmr_bstrm_seq_loader.sv
// Sequence loader for the NMR bitstream pulse engine: packs host beats into
// sequence words, writes them into the sequence SRAM, then fires the engine
// and waits for it to finish. Data widths other than the SRAM address are
// fixed by the sequence word format defined in nmr_bstrm_pkg.
module nmr_bstrm_seq_loader
    import nmr_bstrm_pkg::*;
#(
    parameter int HOST_WIDTH        = SEQ_HOST_W,
    parameter int SRAM_ADDR_WIDTH   = SEQ_AW,
    parameter int SRAM_DAT_WIDTH    = SEQ_DAT_W,
    parameter int SRAM_BYTEEN_WIDTH = SEQ_BE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         go,
    input  logic [HOST_WIDTH-1:0]        host_dat,
    input  logic                         host_valid,
    input  logic                         host_last,
    output logic                         host_ready,
    output logic                         sram_sel,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
    output logic                         sram_cs,
    output logic                         sram_clken,
    output logic                         sram_wr,
    output logic [SRAM_DAT_WIDTH-1:0]    sram_wr_dat,
    output logic [SRAM_BYTEEN_WIDTH-1:0] sram_byteen,
    output logic                         bstrm_start,
    input  logic                         bstrm_done,
    output logic [SRAM_ADDR_WIDTH:0]     nwords,
    output logic                         busy,
    output logic                         loaded,
    output logic                         err_ovf
);

    seq_ld_state_t             state;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_ADDR_WIDTH:0]   word_cnt;
    logic                       ovf;

    logic                       arm_take;
    logic                       accept;
    logic                       pk_clear;
    logic                       pk_valid;
    logic                       pk_done;
    logic [SEQ_DAT_W-1:0]       pk_word;
    logic                       pk_last;

    // ARM is only honoured where a restart is safe; beats reach the packer
    // only while loading, so drained beats never touch the pack register
    always_comb begin
        arm_take = arm && ((state == IDLE) || (state == LOAD) ||
                           (state == DRAIN) || (state == LOADED));
        accept   = host_valid && host_ready;
        pk_valid = (state == LOAD) && host_valid;
        pk_clear = (state == WRITE) || arm_take;
    end

    nmr_bstrm_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .beat_valid (pk_valid),
        .beat_dat   (host_dat),
        .beat_last  (host_last),
        .word_done  (pk_done),
        .word       (pk_word),
        .word_last  (pk_last)
    );

    // Loader FSM with write address, word count and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            word_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE, LOADED: begin
                    if (arm_take) begin
                        state    <= LOAD;
                        addr     <= '0;
                        word_cnt <= '0;
                        ovf      <= 1'b0;
                    end else if ((state == LOADED) && go) begin
                        state <= FIRE;
                    end
                end
                LOAD: begin
                    if (arm_take) begin
                        addr     <= '0;
                        word_cnt <= '0;
                        ovf      <= 1'b0;
                    end else if (pk_done) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 1'b1;
                    if (pk_last) begin
                        state <= LOADED;
                    end else if (&addr) begin
                        state <= DRAIN;
                        ovf   <= 1'b1;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= LOAD;
                    end
                end
                DRAIN: begin
                    if (arm_take) begin
                        state    <= LOAD;
                        addr     <= '0;
                        word_cnt <= '0;
                        ovf      <= 1'b0;
                    end else if (accept && host_last) begin
                        state <= IDLE;
                    end
                end
                FIRE: begin
                    state <= RUN;
                end
                RUN: begin
                    if (bstrm_done) begin
                        state <= LOADED;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Port and status decode straight from the state so reset forces all zero
    always_comb begin
        host_ready  = (state == LOAD) || (state == DRAIN);
        sram_sel    = (state == LOAD) || (state == WRITE) || (state == DRAIN);
        sram_addr   = addr;
        sram_cs     = (state == WRITE);
        sram_clken  = (state == WRITE);
        sram_wr     = (state == WRITE);
        sram_wr_dat = (state == WRITE) ? pk_word : '0;
        sram_byteen = {SRAM_BYTEEN_WIDTH{state == WRITE}};
        bstrm_start = (state == FIRE);
        nwords      = word_cnt;
        busy        = (state != IDLE) && (state != LOADED);
        loaded      = (state == LOADED);
        err_ovf     = ovf;
    end

endmodule

// File: tb/tb_nmr_bstrm_seq_loader.sv
// Self-checking bench for nmr_bstrm_seq_loader: random host beat streams,
// expected SRAM writes from a word-index model pushed to a scoreboard queue,
// and a negedge monitor that checks every write the DUT issues.
module tb_nmr_bstrm_seq_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         arm;
    logic         go;
    logic [31:0]  host_dat;
    logic         host_valid;
    logic         host_last;
    logic         host_ready;
    logic         sram_sel;
    logic [7:0]   sram_addr;
    logic         sram_cs;
    logic         sram_clken;
    logic         sram_wr;
    logic [127:0] sram_wr_dat;
    logic [15:0]  sram_byteen;
    logic         bstrm_start;
    logic         bstrm_done;
    logic [8:0]   nwords;
    logic         busy;
    logic         loaded;
    logic         err_ovf;

    typedef struct {
        logic [7:0]   addr;
        logic [127:0] data;
        int           cyc;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] stim[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_seen = 0;
    int          wr_seen = 0;
    int          s0;
    int          w0;

    nmr_bstrm_seq_loader dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .go          (go),
        .host_dat    (host_dat),
        .host_valid  (host_valid),
        .host_last   (host_last),
        .host_ready  (host_ready),
        .sram_sel    (sram_sel),
        .sram_addr   (sram_addr),
        .sram_cs     (sram_cs),
        .sram_clken  (sram_clken),
        .sram_wr     (sram_wr),
        .sram_wr_dat (sram_wr_dat),
        .sram_byteen (sram_byteen),
        .bstrm_start (bstrm_start),
        .bstrm_done  (bstrm_done),
        .nwords      (nwords),
        .busy        (busy),
        .loaded      (loaded),
        .err_ovf     (err_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe pops one expected write
    always @(negedge clk) begin
        if (!rst) begin
            if (bstrm_start) start_seen <= start_seen + 1;
            if (sram_wr) begin
                wr_seen <= wr_seen + 1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got addr %0d want no write", sram_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("wr_addr", 128'(sram_addr), 128'(mon_e.addr));
                    checkOutput("wr_data", sram_wr_dat, mon_e.data);
                    checkOutput("wr_cycle", 128'(cyc), 128'(mon_e.cyc));
                    checkOutput("wr_strobes", 128'({sram_cs, sram_clken, sram_sel, sram_byteen}),
                                128'({3'b111, 16'hffff}));
                end
            end
        end
    end

    // Drives stim[] as one load; word w holds beats 4w..4w+3 (zero past the
    // end) and is expected one cycle after the beat that completes it
    task automatic applyStimulus(input bit with_last);
        int n;
        int k;
        int guard;
        int w;
        logic [127:0] d;
        n = stim.size();
        k = 0;
        guard = 0;
        while (k < n) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) begin
                host_valid = 1'b0;
                host_last  = 1'b0;
            end else begin
                host_valid = 1'b1;
                host_dat   = stim[k];
                host_last  = with_last && (k == n - 1);
                if (host_ready) begin
                    if ((k % 4 == 3) || (with_last && k == n - 1)) begin
                        w = k / 4;
                        if (w < 256) begin
                            d = '0;
                            for (int l = 0; l < 4; l++)
                                if (4 * w + l < n) d[l*32 +: 32] = stim[4*w+l];
                            exp_q.push_back('{addr: 8'(w), data: d, cyc: cyc + 1});
                        end
                    end
                    k++;
                end
            end
            guard++;
            if (guard > 8 * n + 200) begin
                total++;
                bad++;
                $display("[TB] FAIL beat_timeout: got %0d beats accepted want %0d", k, n);
                break;
            end
        end
        @(negedge clk);
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checkOutput("settle_busy", 128'(busy), 128'(0));
    endtask

    task automatic pulse_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic pulse_go();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back($urandom());
    endtask

    task automatic check_all_zero(input string name);
        checkOutput(name, 128'({host_ready, sram_sel, sram_addr, sram_cs, sram_clken, sram_wr,
                                sram_byteen, bstrm_start, nwords, busy, loaded, err_ovf}), 128'(0));
        checkOutput({name, "_dat"}, sram_wr_dat, 128'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        arm        = 1'b0;
        go         = 1'b0;
        host_dat   = '0;
        host_valid = 1'b0;
        host_last  = 1'b0;
        bstrm_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outs");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_outs");

        $display("[TB] GO while idle is ignored");
        pulse_go();
        @(negedge clk);
        checkOutput("go_idle_start", 128'(start_seen), 128'(0));
        checkOutput("go_idle_busy", 128'(busy), 128'(0));

        $display("[TB] two-word load");
        pulse_arm();
        checkOutput("arm_ready", 128'({host_ready, sram_sel, busy}), 128'(3'b111));
        fill_random(8);
        applyStimulus(1'b1);
        wait_not_busy();
        checkOutput("t1_nwords", 128'(nwords), 128'(2));
        checkOutput("t1_status", 128'({loaded, sram_sel, host_ready, err_ovf}), 128'(4'b1000));
        checkOutput("t1_pending", 128'(exp_q.size()), 128'(0));

        $display("[TB] field packing 0,5,8,5 with LOOP=4");
        pulse_arm();
        stim.delete();
        stim.push_back(32'h0004_0000);
        stim.push_back(32'd5);
        stim.push_back(32'd8);
        stim.push_back(32'd5);
        applyStimulus(1'b1);
        wait_not_busy();
        checkOutput("t2_nwords", 128'(nwords), 128'(1));

        $display("[TB] short word zero fill");
        pulse_arm();
        fill_random(2);
        applyStimulus(1'b1);
        wait_not_busy();
        checkOutput("t3_nwords", 128'(nwords), 128'(1));
        checkOutput("t3_loaded", 128'(loaded), 128'(1));

        $display("[TB] fire and re-fire");
        s0 = start_seen;
        pulse_go();
        repeat (4) @(negedge clk);
        checkOutput("t4_start1", 128'(start_seen - s0), 128'(1));
        checkOutput("t4_run", 128'({busy, loaded, sram_sel}), 128'(3'b100));
        bstrm_done = 1'b1;
        @(negedge clk) bstrm_done = 1'b0;
        checkOutput("t4_done", 128'({loaded, busy}), 128'(2'b10));
        bstrm_done = 1'b1;
        pulse_go();
        @(negedge clk);
        wait_not_busy();
        bstrm_done = 1'b0;
        checkOutput("t4_start2", 128'(start_seen - s0), 128'(2));
        checkOutput("t4_reloaded", 128'(loaded), 128'(1));

        $display("[TB] ARM and GO together");
        @(negedge clk);
        arm = 1'b1;
        go  = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        go  = 1'b0;
        @(negedge clk);
        checkOutput("armgo_start", 128'(start_seen - s0), 128'(2));
        checkOutput("armgo_load", 128'({host_ready, nwords}), 128'({1'b1, 9'd0}));

        $display("[TB] overflow: 257 words");
        w0 = wr_seen;
        fill_random(257 * 4);
        applyStimulus(1'b1);
        wait_not_busy();
        checkOutput("t5_writes", 128'(wr_seen - w0), 128'(256));
        checkOutput("t5_nwords", 128'(nwords), 128'(256));
        checkOutput("t5_status", 128'({err_ovf, loaded, host_ready, sram_sel}), 128'(4'b1000));
        checkOutput("t5_pending", 128'(exp_q.size()), 128'(0));
        pulse_arm();
        checkOutput("t5_clear", 128'({err_ovf, nwords}), 128'(0));

        $display("[TB] restart mid-load");
        fill_random(12);
        applyStimulus(1'b0);
        repeat (3) @(negedge clk);
        checkOutput("t6_partial", 128'(nwords), 128'(3));
        pulse_arm();
        checkOutput("t6_rearm", 128'(nwords), 128'(0));
        fill_random(4);
        applyStimulus(1'b1);
        wait_not_busy();
        checkOutput("t6_nwords", 128'(nwords), 128'(1));
        checkOutput("t6_loaded", 128'(loaded), 128'(1));

        $display("[TB] reset during run");
        pulse_go();
        repeat (2) @(negedge clk);
        checkOutput("t6_running", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        check_all_zero("rst_run_outs");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst", 128'({busy, loaded, sram_sel}), 128'(0));
        checkOutput("final_pending", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
